// File: rtl/aurora_link_supervisor.sv
// Aurora link bring-up supervisor: sequences PMA/PB resets, waits for channel up,
// restarts on timeout or link loss, and keeps saturating error/restart statistics.
module aurora_link_supervisor #(
    parameter int PMA_INIT_CYCLES = 1024,
    parameter int RESET_PB_CYCLES = 128,
    parameter int TIMEOUT_CYCLES  = 1000000,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                 sysClk,
    input  logic                 sysReset,
    input  logic                 enable,
    input  logic                 channelUp,
    input  logic                 hardErr,
    input  logic                 softErr,
    input  logic                 forceReset,
    input  logic                 clearCounts,
    output logic                 resetPb,
    output logic                 pmaInit,
    output logic                 linkUp,
    output logic [2:0]           state,
    output logic [CNT_WIDTH-1:0] restartCount,
    output logic [CNT_WIDTH-1:0] hardErrCount,
    output logic [CNT_WIDTH-1:0] softErrCount
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PMA_RESET = 3'd1,
        PB_RESET  = 3'd2,
        WAIT_UP   = 3'd3,
        RUNNING   = 3'd4
    } state_t;

    localparam int MAX_AB  = (PMA_INIT_CYCLES > RESET_PB_CYCLES) ? PMA_INIT_CYCLES : RESET_PB_CYCLES;
    localparam int MAX_CYC = (MAX_AB > TIMEOUT_CYCLES) ? MAX_AB : TIMEOUT_CYCLES;
    localparam int DWELL_W = $clog2(MAX_CYC + 1);

    state_t               cur_state;
    state_t               next_state;
    logic                 restart;
    logic [DWELL_W-1:0]   dwell;

    assign state = cur_state;

    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    always_comb begin
        next_state = cur_state;
        restart    = 1'b0;
        if (!enable) begin
            next_state = IDLE;
        end else begin
            case (cur_state)
                IDLE: next_state = PMA_RESET;
                PMA_RESET: begin
                    if (forceReset)
                        restart = 1'b1;
                    else if (dwell == DWELL_W'(PMA_INIT_CYCLES - 1))
                        next_state = PB_RESET;
                end
                PB_RESET: begin
                    if (forceReset)
                        restart = 1'b1;
                    else if (dwell == DWELL_W'(RESET_PB_CYCLES - 1))
                        next_state = WAIT_UP;
                end
                WAIT_UP: begin
                    if (forceReset)
                        restart = 1'b1;
                    else if (channelUp)
                        next_state = RUNNING;
                    else if (dwell == DWELL_W'(TIMEOUT_CYCLES - 1))
                        restart = 1'b1;
                end
                RUNNING: begin
                    // Simultaneous loss causes collapse into a single restart event.
                    if (!channelUp || hardErr || forceReset)
                        restart = 1'b1;
                end
                default: next_state = IDLE;
            endcase
            if (restart)
                next_state = PMA_RESET;
        end
    end

    // NOTE: state and counters are flops, so they are only ever assigned with <=.
    always_ff @(posedge sysClk or posedge sysReset) begin
        if (sysReset) begin
            cur_state    <= IDLE;
            dwell        <= '0;
            resetPb      <= 1'b1;
            pmaInit      <= 1'b1;
            linkUp       <= 1'b0;
            restartCount <= '0;
            hardErrCount <= '0;
            softErrCount <= '0;
        end else begin
            cur_state <= next_state;
            resetPb   <= (next_state == IDLE) || (next_state == PMA_RESET) || (next_state == PB_RESET);
            pmaInit   <= (next_state == IDLE) || (next_state == PMA_RESET);
            linkUp    <= (next_state == RUNNING);

            // A restart re-enters PMA_RESET, so it must clear the dwell even without a state change.
            if (restart || (next_state != cur_state))
                dwell <= '0;
            else if ((cur_state == PMA_RESET) || (cur_state == PB_RESET) || (cur_state == WAIT_UP))
                dwell <= dwell + DWELL_W'(1);

            if (clearCounts) begin
                restartCount <= '0;
                hardErrCount <= '0;
                softErrCount <= '0;
            end else begin
                if (restart && (restartCount != '1))
                    restartCount <= restartCount + CNT_WIDTH'(1);
                if (hardErr && (hardErrCount != '1))
                    hardErrCount <= hardErrCount + CNT_WIDTH'(1);
                if (softErr && (softErrCount != '1))
                    softErrCount <= softErrCount + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: doc/aurora_link_supervisor.md
AURORA_LINK_SUPERVISOR -- requirements
Module: aurora_link_supervisor

Interface
REQ-001 The block SHALL have parameter PMA_INIT_CYCLES, default 1024: number of cycles pmaInit is held in the PMA_RESET state.
REQ-002 The block SHALL have parameter RESET_PB_CYCLES, default 128: number of cycles resetPb alone is held in the PB_RESET state.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 1000000: maximum number of cycles spent in WAIT_UP before a restart.
REQ-004 The block SHALL have parameter CNT_WIDTH, default 16: width of the statistics counters.
REQ-005 The block SHALL have port sysClk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port sysReset, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port enable, input, 1 bit: 1 runs the link; 0 holds the Aurora core in reset.
REQ-008 The block SHALL have ports channelUp, hardErr, softErr, input, 1 bit each: Aurora status, already synchronous to sysClk.
REQ-009 The block SHALL have port forceReset, input, 1 bit: a one-cycle request to restart the link.
REQ-010 The block SHALL have port clearCounts, input, 1 bit: synchronous clear of all statistics counters.
REQ-011 The block SHALL have ports resetPb and pmaInit, output, 1 bit each: reset controls to the Aurora core.
REQ-012 The block SHALL have port linkUp, output, 1 bit: 1 while in the RUNNING state.
REQ-013 The block SHALL have port state, output, 3 bits: IDLE=0, PMA_RESET=1, PB_RESET=2, WAIT_UP=3, RUNNING=4.
REQ-014 The block SHALL have ports restartCount, hardErrCount and softErrCount, output, CNT_WIDTH bits each: statistics counters.

Function
REQ-015 All outputs SHALL be registered; resetPb, pmaInit and linkUp SHALL be decoded from the registered state.
REQ-016 In IDLE, resetPb=1 and pmaInit=1; IDLE SHALL go to PMA_RESET on the first cycle with enable=1.
REQ-017 In PMA_RESET, resetPb=1 and pmaInit=1 for exactly PMA_INIT_CYCLES cycles, then the state SHALL go to PB_RESET.
REQ-018 In PB_RESET, resetPb=1 and pmaInit=0 for exactly RESET_PB_CYCLES cycles, then the state SHALL go to WAIT_UP.
REQ-019 In WAIT_UP, both resets are 0; channelUp=1 SHALL go to RUNNING on the next cycle.
REQ-020 If channelUp is still 0 after TIMEOUT_CYCLES cycles in WAIT_UP, the state SHALL go to PMA_RESET and restartCount SHALL increment.
REQ-021 In RUNNING, linkUp=1; channelUp=0, hardErr=1 or forceReset=1 SHALL go to PMA_RESET and increment restartCount by exactly 1, even when these occur together.
REQ-022 forceReset in PMA_RESET, PB_RESET or WAIT_UP SHALL restart PMA_RESET timing from zero and increment restartCount.
REQ-023 enable=0 in any state SHALL go to IDLE next cycle with no restartCount increment; enable=0 has priority over every other transition.
REQ-024 The dwell counter SHALL be wide enough for the largest of the cycle parameters and SHALL clear on every state entry.
REQ-025 hardErrCount and softErrCount SHALL increment on each cycle their input is 1, in any state.
REQ-026 All counters SHALL saturate at all-ones and never wrap.
REQ-027 clearCounts SHALL zero all three counters next cycle, taking priority over a same-cycle increment; it SHALL NOT affect the state.

Reset
REQ-028 When sysReset is asserted, the block SHALL immediately (asynchronously) reach state=IDLE, resetPb=1, pmaInit=1, linkUp=0, all counters 0 and the dwell counter 0.
REQ-029 When sysReset is released, the block SHALL begin operating on the next sysClk edge; sysReset asserted mid-sequence SHALL abort the sequence with no partial output glitch to 0.

Verification (PMA_INIT_CYCLES=8, RESET_PB_CYCLES=4, TIMEOUT_CYCLES=32, CNT_WIDTH=4)
REQ-030 Bring-up: release sysReset, set enable=1, then raise channelUp 5 cycles into WAIT_UP -> pmaInit high for exactly 8 cycles, then resetPb high for exactly 4 cycles, then RUNNING with linkUp=1 and restartCount=0.
REQ-031 Timeout: hold channelUp=0 -> WAIT_UP lasts 32 cycles, then PMA_RESET with restartCount=1; after 16 such timeouts restartCount=15 (saturated).
REQ-032 Link loss: in RUNNING, drop channelUp together with hardErr=1 for one cycle -> PMA_RESET next cycle, restartCount increments by 1, hardErrCount=1.
REQ-033 Priority: drive enable=0 and forceReset=1 in the same cycle during PB_RESET -> IDLE next cycle with restartCount unchanged.
REQ-034 Clear: softErr=1 for 20 cycles, then clearCounts=1 coincident with softErr=1 -> softErrCount reads 15, then 0.
REQ-035 Reset mid-operation: assert sysReset during RUNNING -> linkUp=0, resetPb=1, pmaInit=1 with no clock edge, and all counters read 0.
